// File: rtl/angle_weight_seq.sv
// Angular intra-prediction sample sequencer: per-sample weights and reference indices
// from a running (k+1)*angle accumulator. Optional stall counter: ANGLE_SEQ_STALL_CNT_EN.
module angle_weight_seq #(
  parameter int ACC_W = 13,
  parameter int IDX_W = 9
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [2:0]              PU,
  input  logic signed [6:0]       ANGLE,
  input  logic                    IS_HOR,
  output logic                    BUSY,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [5:0]              X,
  output logic [5:0]              Y,
  output logic [7:0]              WEIGHT1,
  output logic [7:0]              WEIGHT2,
  output logic signed [IDX_W-1:0] REF_IDX1,
  output logic signed [IDX_W-1:0] REF_IDX2,
  output logic                    ANGLE_OR_PLANAR,
  output logic                    LAST,
`ifdef ANGLE_SEQ_STALL_CNT_EN
  output logic [15:0]             STALL_CNT,
`endif
  output logic                    DONE
);

  // ANGLE spans -32..+32 inclusive, so it is carried as a 7-bit signed value.
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_TWO = ACC_W'(2);

  state_t                   state_q, state_d;
  logic [5:0]               nt_m1_q, nt_m1_d;
  logic signed [6:0]        angle_q, angle_d;
  logic                     is_hor_q, is_hor_d;
  logic [5:0]               outer_q, outer_d;
  logic [5:0]               inner_q, inner_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic [5:0]               x_q, x_d, y_q, y_d;
  logic [7:0]               w1_q, w1_d, w2_q, w2_d;
  logic signed [IDX_W-1:0]  ref1_q, ref1_d, ref2_q, ref2_d;
  logic                     last_q, last_d;

  logic                     load_desc, clear_desc;
  logic [5:0]               pu_nt_m1;
  logic signed [ACC_W-1:0]  angle_ext_in, angle_ext_q;
  logic signed [ACC_W-1:0]  i_idx, m_ext, ref1_full, ref2_full;
  logic [4:0]               i_fact;

  always_comb begin
    case (PU)
      3'd0:    pu_nt_m1 = 6'd3;
      3'd1:    pu_nt_m1 = 6'd7;
      3'd2:    pu_nt_m1 = 6'd15;
      3'd3:    pu_nt_m1 = 6'd31;
      default: pu_nt_m1 = 6'd63;
    endcase
  end

  assign angle_ext_in = {{(ACC_W-7){ANGLE[6]}}, ANGLE};
  assign angle_ext_q  = {{(ACC_W-7){angle_q[6]}}, angle_q};

  always_comb begin
    state_d    = state_q;
    nt_m1_d    = nt_m1_q;
    angle_d    = angle_q;
    is_hor_d   = is_hor_q;
    outer_d    = outer_q;
    inner_d    = inner_q;
    acc_d      = acc_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    load_desc  = 1'b0;
    clear_desc = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (START) begin
          state_d   = S_RUN;
          nt_m1_d   = pu_nt_m1;
          angle_d   = ANGLE;
          is_hor_d  = IS_HOR;
          outer_d   = 6'd0;
          inner_d   = 6'd0;
          acc_d     = angle_ext_in;
          valid_d   = 1'b1;
          load_desc = 1'b1;
        end
      end
      S_RUN: begin
        if (valid_q && OUT_READY) begin
          if (last_q) begin
            state_d    = S_IDLE;
            valid_d    = 1'b0;
            done_d     = 1'b1;
            clear_desc = 1'b1;
          end else begin
            load_desc = 1'b1;
            if (inner_q < nt_m1_q) begin
              inner_d = inner_q + 6'd1;
            end else begin
              inner_d = 6'd0;
              outer_d = outer_q + 6'd1;
              acc_d   = acc_q + angle_ext_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Descriptor for the sample that becomes current next cycle; m is always the inner index.
  assign i_idx     = acc_d >>> 5;
  assign i_fact    = acc_d[4:0];
  assign m_ext     = {{(ACC_W-6){1'b0}}, inner_d};
  assign ref1_full = m_ext + i_idx + ACC_ONE;
  assign ref2_full = m_ext + i_idx + ACC_TWO;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    w1_d   = w1_q;
    w2_d   = w2_q;
    ref1_d = ref1_q;
    ref2_d = ref2_q;
    last_d = last_q;
    if (load_desc) begin
      x_d    = is_hor_d ? outer_d : inner_d;
      y_d    = is_hor_d ? inner_d : outer_d;
      w1_d   = 8'd32 - {3'b000, i_fact};
      w2_d   = {3'b000, i_fact};
      ref1_d = ref1_full[IDX_W-1:0];
      ref2_d = ref2_full[IDX_W-1:0];
      last_d = (outer_d == nt_m1_d) && (inner_d == nt_m1_d);
    end else if (clear_desc) begin
      x_d    = 6'd0;
      y_d    = 6'd0;
      w1_d   = 8'd0;
      w2_d   = 8'd0;
      ref1_d = '0;
      ref2_d = '0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      nt_m1_q  <= 6'd0;
      angle_q  <= 7'sd0;
      is_hor_q <= 1'b0;
      outer_q  <= 6'd0;
      inner_q  <= 6'd0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= 6'd0;
      y_q      <= 6'd0;
      w1_q     <= 8'd0;
      w2_q     <= 8'd0;
      ref1_q   <= '0;
      ref2_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nt_m1_q  <= nt_m1_d;
      angle_q  <= angle_d;
      is_hor_q <= is_hor_d;
      outer_q  <= outer_d;
      inner_q  <= inner_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      ref1_q   <= ref1_d;
      ref2_q   <= ref2_d;
      last_q   <= last_d;
    end
  end

`ifdef ANGLE_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= 16'd0;
    end else if (state_q == S_IDLE && START) begin
      stall_cnt_q <= 16'd0;
    end else if (valid_q && !OUT_READY && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

  assign BUSY            = (state_q == S_RUN);
  assign OUT_VALID       = valid_q;
  assign ANGLE_OR_PLANAR = valid_q;
  assign DONE            = done_q;
  assign X               = x_q;
  assign Y               = y_q;
  assign WEIGHT1         = w1_q;
  assign WEIGHT2         = w2_q;
  assign REF_IDX1        = ref1_q;
  assign REF_IDX2        = ref2_q;
  assign LAST            = last_q;

endmodule
